aes_round_seq: RTL and testbench
================================

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001: clk  in  1  single clock; all state updates on rising edge.
REQ-002: rst  in  1  synchronous, active-high reset.
REQ-003: in_valid  in  1  plaintext/key offered.
REQ-004: in_ready  out  1  block idle, can accept.
REQ-005: in_pt  in  128  plaintext, byte 0 at [7:0].
REQ-006: in_key  in  128  cipher key, byte 0 at [7:0].
REQ-007: out_valid  out  1  ciphertext available.
REQ-008: out_ready  in  1  consumer accepts ciphertext.
REQ-009: out_ct  out  128  ciphertext, byte 0 at [7:0].
REQ-010: rnd_state_in  out  128  state to round datapath.
REQ-011: rnd_key_in  out  128  current round key to round datapath.
REQ-012: rnd_rcon  out  8  RCON for next-key derivation.
REQ-013: rnd_last  out  1  final round; datapath skips MixColumns.
REQ-014: rnd_state_out  in  128  datapath result: ARK(key_in), SubBytes, ShiftRows, MixColumns unless rnd_last.
REQ-015: rnd_key_out  in  128  next round key from datapath.

Function
REQ-016: The FSM SHALL have states IDLE, RUN and DONE.
REQ-017: In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018: On in_valid&in_ready, state_reg<=in_pt, key_reg<=in_key, rcon_reg<=8'h01, cnt<=1, and the FSM SHALL move to RUN.
REQ-019: In RUN, in_ready SHALL be 0; rnd_state_in=state_reg, rnd_key_in=key_reg, rnd_rcon=rcon_reg, rnd_last=(cnt==10).
REQ-020: In RUN with cnt<10, each edge: state_reg<=rnd_state_out, key_reg<=rnd_key_out, rcon_reg<=xtime(rcon_reg) (shift left, XOR 8'h1B on carry), cnt<=cnt+1.
REQ-021: In RUN with cnt==10, state_reg<=rnd_state_out^rnd_key_out and the FSM SHALL move to DONE.
REQ-022: The RCON sequence over rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-023: In DONE, out_valid=1, out_ct=state_reg, in_ready=0; out_ct SHALL hold stable until accepted.
REQ-024: On out_valid&out_ready, the FSM SHALL return to IDLE; a new input is accepted no earlier than the following cycle (no overlap).
REQ-025: Latency SHALL be exactly 10 cycles from the accept edge to the first cycle with out_valid=1; throughput SHALL be at most one block per 12 cycles.
REQ-026: in_valid during RUN/DONE SHALL be ignored; in_pt/in_key are sampled only on the accept edge.
REQ-027: out_ct SHALL be 0 whenever out_valid=0.
REQ-028: rnd_state_in, rnd_key_in and rnd_rcon SHALL be 0 and rnd_last 0 outside RUN.

Reset
REQ-029: rst SHALL, in any state including mid-RUN, force IDLE, cnt=0, rcon_reg=8'h01, state_reg=0 and key_reg=0 on the next edge, with no output produced for the aborted block.
REQ-030: Output values after reset: in_ready=1, out_valid=0, out_ct=0, rnd_last=0.

Structure
REQ-031: Package aes_ctrl_pkg SHALL hold the FSM state enum, NB_ROUNDS=10, RCON_INIT=8'h01 and RCON_POLY=8'h1B.
REQ-032: The single sub-module aes_rcon_gen SHALL hold rcon_reg with load/step inputs.
REQ-033: The round datapath SHALL stay outside this block and be connected through the rnd_* ports; the bench SHALL connect the team's unmasked round with a last-round option.

Verification
REQ-034: FIPS-197 App. B: in_pt=128'h340737e0_a2983131_8d305a88_a8f64332, in_key=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b -> first RUN cycle rnd_state_out=128'h4c260628_7ad3f848_9a19cbe0_e5816604, rnd_key_out=128'h05766c2a_3939a323_b12c5488_17fefaa0; out_ct=128'h320b6a19_978511dc_fb09dc02_1d842539 after exactly 10 cycles.
REQ-035: FIPS-197 C.1: in_pt=128'hffeeddcc_bbaa9988_77665544_33221100, in_key=128'h0f0e0d0c_0b0a0908_07060504_03020100 -> out_ct=128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469.
REQ-036: Monitor rnd_rcon per RUN cycle -> 01,02,04,08,10,20,40,80,1B,36; rnd_last=1 only in the 10th cycle.
REQ-037: Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_ct stable, in_ready=0; in_valid pulses ignored; after out_ready=1, IDLE with in_ready=1 next cycle.
REQ-038: Assert rst at cnt=5 -> next cycle in_ready=1, out_valid=0; a following App. B run gives the correct out_ct.
REQ-039: Back-to-back blocks with in_valid and out_ready held at 1 -> blocks accepted every 12 cycles with correct ciphertexts.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } aes_fsm_e;

    localparam int unsigned NB_ROUNDS = 10;
    localparam int unsigned CNT_W     = 4;

    // Round counter value during the final round.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_ROUNDS);

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Handshake and round-datapath signals of the AES round sequencer.
// The slave side is the sequencer; the master side is its environment
// (block producer/consumer plus the external round datapath).
interface aes_round_seq_if ();

    // Input handshake
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_pt;
    logic [127:0] in_key;

    // Output handshake
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_ct;

    // Round datapath link
    logic [127:0] rnd_state_in;
    logic [127:0] rnd_key_in;
    logic [7:0]   rnd_rcon;
    logic         rnd_last;
    logic [127:0] rnd_state_out;
    logic [127:0] rnd_key_out;

    modport master (
        output in_valid,
        output in_pt,
        output in_key,
        output out_ready,
        output rnd_state_out,
        output rnd_key_out,
        input  in_ready,
        input  out_valid,
        input  out_ct,
        input  rnd_state_in,
        input  rnd_key_in,
        input  rnd_rcon,
        input  rnd_last
    );

    modport slave (
        input  in_valid,
        input  in_pt,
        input  in_key,
        input  out_ready,
        input  rnd_state_out,
        input  rnd_key_out,
        output in_ready,
        output out_valid,
        output out_ct,
        output rnd_state_in,
        output rnd_key_in,
        output rnd_rcon,
        output rnd_last
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads the first RCON when a block is accepted
// and advances by xtime once per non-final round.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Next RCON: load wins over step.
    always_comb begin
        rcon_d = rcon_q;
        if (load) begin
            rcon_d = RCON_INIT;
        end else if (step) begin
            rcon_d = xtime(rcon_q);
        end
    end

    // RCON register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_seq.sv
// AES-128 round sequencer. Accepts a plaintext/key pair, iterates the
// external round datapath ten times, applies the final AddRoundKey and
// holds the ciphertext until the consumer takes it. One block in flight.
module aes_round_seq
    import aes_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_round_seq_if.slave bus
);

    aes_fsm_e         fsm_q;
    aes_fsm_e         fsm_d;
    logic [127:0]     state_q;
    logic [127:0]     state_d;
    logic [127:0]     key_q;
    logic [127:0]     key_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             rcon_load;
    logic             rcon_step;
    logic [7:0]       rcon;
    logic             is_last;

    assign is_last = (cnt_q == LAST_CNT);

    aes_rcon_gen u_rcon_gen (
        .clk  (clk),
        .rst  (rst),
        .load (rcon_load),
        .step (rcon_step),
        .rcon (rcon)
    );

    // Next-state and output decode; every output defaults to its idle/zero value.
    always_comb begin
        fsm_d            = fsm_q;
        state_d          = state_q;
        key_d            = key_q;
        cnt_d            = cnt_q;
        rcon_load        = 1'b0;
        rcon_step        = 1'b0;

        bus.in_ready     = 1'b0;
        bus.out_valid    = 1'b0;
        bus.out_ct       = '0;
        bus.rnd_state_in = '0;
        bus.rnd_key_in   = '0;
        bus.rnd_rcon     = '0;
        bus.rnd_last     = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d   = bus.in_pt;
                    key_d     = bus.in_key;
                    cnt_d     = CNT_W'(1);
                    rcon_load = 1'b1;
                    fsm_d     = StRun;
                end
            end

            StRun: begin
                bus.rnd_state_in = state_q;
                bus.rnd_key_in   = key_q;
                bus.rnd_rcon     = rcon;
                bus.rnd_last     = is_last;
                if (is_last) begin
                    // Final AddRoundKey with the last round key.
                    state_d = bus.rnd_state_out ^ bus.rnd_key_out;
                    fsm_d   = StDone;
                end else begin
                    state_d   = bus.rnd_state_out;
                    key_d     = bus.rnd_key_out;
                    rcon_step = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                bus.out_valid = 1'b1;
                bus.out_ct    = state_q;
                if (bus.out_ready) begin
                    cnt_d = '0;
                    fsm_d = StIdle;
                end
            end

            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset also aborts a block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ciphertext must hold while the consumer stalls.
    a_ct_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_ct)));

    // Accepting and presenting never overlap.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid));

    // The final-round flag only appears while rounds are running.
    a_last_in_run: assert property (@(posedge clk) disable iff (rst)
        bus.rnd_last |-> (!bus.in_ready && !bus.out_valid));

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: supplies an unmasked AES round datapath, a
// whole-cipher AES-128 reference, known-answer vectors, random blocks and
// hand-written sequences for stall, reset-abort and back-to-back traffic.
module tb_aes_round_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_round_seq_if bus ();

    aes_round_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] v;
        p = x;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            v = gmul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // ---------------- round datapath (environment) ----------------
    function automatic logic [127:0] dp_state(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[8*i +: 8] ^ k[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = b[4*c+r];
            end else begin
                o[8*(4*c)   +: 8] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1])
                                    ^ b[4*c+2] ^ b[4*c+3];
                o[8*(4*c+1) +: 8] = b[4*c] ^ gmul(8'h02, b[4*c+1])
                                    ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                o[8*(4*c+2) +: 8] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2])
                                    ^ gmul(8'h03, b[4*c+3]);
                o[8*(4*c+3) +: 8] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2]
                                    ^ gmul(8'h02, b[4*c+3]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] dp_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
        t = {sbox(w[3][7:0]), sbox(w[3][31:24]), sbox(w[3][23:16]), sbox(w[3][15:8])};
        t = t ^ {24'h0, rc};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    assign bus.rnd_state_out = dp_state(bus.rnd_state_in, bus.rnd_key_in, bus.rnd_last);
    assign bus.rnd_key_out   = dp_key(bus.rnd_key_in, bus.rnd_rcon);

    // ---------------- whole-cipher reference ----------------
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st [4][4];
        logic [7:0]   ks [11][4][4];
        logic [7:0]   rcon_tab [10];
        logic [7:0]   tmp [4];
        logic [127:0] o;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ks[0][r][c] = key[8*(4*c+r) +: 8];
        for (int n = 1; n <= 10; n++) begin
            for (int r = 0; r < 4; r++) tmp[r] = sbox(ks[n-1][(r+1)%4][3]);
            tmp[0] = tmp[0] ^ rcon_tab[n-1];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (c == 0) ks[n][r][c] = ks[n-1][r][c] ^ tmp[r];
                    else        ks[n][r][c] = ks[n-1][r][c] ^ ks[n][r][c-1];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = pt[8*(4*c+r) +: 8] ^ ks[0][r][c];
        for (int n = 1; n <= 10; n++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] = sbox(st[r][c]);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) tmp[c] = st[r][(c+r)%4];
                for (int c = 0; c < 4; c++) st[r][c] = tmp[c];
            end
            if (n < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) tmp[r] = st[r][c];
                    st[0][c] = gmul(8'h02, tmp[0]) ^ gmul(8'h03, tmp[1]) ^ tmp[2] ^ tmp[3];
                    st[1][c] = tmp[0] ^ gmul(8'h02, tmp[1]) ^ gmul(8'h03, tmp[2]) ^ tmp[3];
                    st[2][c] = tmp[0] ^ tmp[1] ^ gmul(8'h02, tmp[2]) ^ gmul(8'h03, tmp[3]);
                    st[3][c] = gmul(8'h03, tmp[0]) ^ tmp[1] ^ tmp[2] ^ gmul(8'h02, tmp[3]);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ ks[n][r][c];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = st[r][c];
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the sequencer is idle.
    task automatic wait_idle();
        int k;
        k = 0;
        while (!bus.in_ready && k < 40) begin
            tick();
            k++;
        end
        if (!bus.in_ready) chk("idle_timeout", 128'(bus.in_ready), 128'(1));
    endtask

    // Runs one block; caller compares the returned ciphertext.
    task automatic do_block(input logic [127:0] pt, input logic [127:0] key,
                            input int ready_delay, input logic chk_rcon,
                            output logic [127:0] ct);
        logic [7:0] rc_exp [10];
        int         lat;
        rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        wait_idle();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pt     = pt;
        bus.in_key    = key;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_pt     = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key    = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (chk_rcon) begin
                if (lat < 10) chk("rnd_rcon", 128'(bus.rnd_rcon), 128'(rc_exp[lat]));
                chk("rnd_last", 128'(bus.rnd_last), 128'(lat == 9));
            end
            chk("run_in_ready", 128'(bus.in_ready), 128'(0));
            chk("run_out_ct", bus.out_ct, 128'(0));
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(10));
        ct = bus.out_ct;
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            chk("stall_valid", 128'(bus.out_valid), 128'(1));
            chk("stall_ct", bus.out_ct, ct);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("after_accept_ready", 128'(bus.in_ready), 128'(1));
        chk("after_accept_valid", 128'(bus.out_valid), 128'(0));
    endtask

    localparam logic [127:0] PT_B   = 128'h340737e0_a2983131_8d305a88_a8f64332;
    localparam logic [127:0] KEY_B  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] CT_B   = 128'h320b6a19_978511dc_fb09dc02_1d842539;
    localparam logic [127:0] PT_C1  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] KEY_C1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] CT_C1  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;

    initial begin
        vec_t         vt [3];
        logic [127:0] ct;
        logic [127:0] rpt;
        logic [127:0] rkey;
        logic [127:0] pts [4];
        logic [127:0] keys [4];
        logic [127:0] exp_q [$];
        int           acc_cyc [$];
        int           nacc;
        int           nout;
        int           cyc;
        int           k;

        vt[0] = '{pt: PT_B, key: KEY_B, ct: CT_B};
        vt[1] = '{pt: PT_C1, key: KEY_C1, ct: CT_C1};
        vt[2] = '{pt: 128'h0, key: 128'h0,
                  ct: 128'h2e2b34ca_59fa4c88_3b2c8aef_d44be966};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pt     = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_ct", bus.out_ct, 128'(0));
        chk("rst_rnd_last", 128'(bus.rnd_last), 128'(0));
        chk("rst_rnd_state_in", bus.rnd_state_in, 128'(0));
        chk("rst_rnd_key_in", bus.rnd_key_in, 128'(0));
        chk("rst_rnd_rcon", 128'(bus.rnd_rcon), 128'(0));
        rst = 1'b0;
        tick();

        // Known-answer table
        for (int i = 0; i < 3; i++) begin
            chk("ref_model_kat", aes_ref(vt[i].pt, vt[i].key), vt[i].ct);
            do_block(vt[i].pt, vt[i].key, i, (i == 0), ct);
            chk("kat_ct", ct, vt[i].ct);
        end

        // First round of App. B, then abort with reset at cnt=5
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_pt    = PT_B;
        bus.in_key   = KEY_B;
        tick();
        bus.in_valid = 1'b0;
        chk("r1_state_in", bus.rnd_state_in, PT_B);
        chk("r1_key_in", bus.rnd_key_in, KEY_B);
        chk("r1_state_out", bus.rnd_state_out, 128'h4c260628_7ad3f848_9a19cbe0_e5816604);
        chk("r1_key_out", bus.rnd_key_out, 128'h05766c2a_3939a323_b12c5488_17fefaa0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_rnd_last", 128'(bus.rnd_last), 128'(0));
        chk("abort_rnd_rcon", 128'(bus.rnd_rcon), 128'(0));
        k = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) k++;
        end
        chk("abort_no_output", 128'(k), 128'(0));
        do_block(PT_B, KEY_B, 0, 1'b1, ct);
        chk("post_abort_ct", ct, CT_B);

        // Stall in DONE with in_valid noise during RUN and DONE
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_pt    = PT_C1;
        bus.in_key   = KEY_C1;
        tick();
        k = 0;
        while (!bus.out_valid && k < 40) begin
            bus.in_pt  = {$urandom, $urandom, $urandom, $urandom};
            bus.in_key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            k++;
        end
        chk("stall_latency", 128'(k), 128'(10));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_ct", bus.out_ct, CT_C1);
            chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
            chk("hold_rnd_state_in", bus.rnd_state_in, 128'(0));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_in_ready", 128'(bus.in_ready), 128'(1));
        chk("release_out_valid", 128'(bus.out_valid), 128'(0));
        chk("release_out_ct", bus.out_ct, 128'(0));
        repeat (3) tick();
        chk("noise_not_taken", 128'(bus.in_ready), 128'(1));

        // Random blocks against the reference
        for (int i = 0; i < 16; i++) begin
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            do_block(rpt, rkey, $urandom_range(0, 3), (i == 5), ct);
            chk("rand_ct", ct, aes_ref(rpt, rkey));
        end

        // Back-to-back with in_valid and out_ready held high
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            pts[i]  = {$urandom, $urandom, $urandom, $urandom};
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        nacc = 0;
        nout = 0;
        cyc  = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        while (nout < 4 && cyc < 100) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_extra_output", 128'(1), 128'(0));
                end else begin
                    chk("b2b_ct", bus.out_ct, exp_q.pop_front());
                end
                nout++;
            end
            if (bus.in_ready && nacc < 4) begin
                bus.in_pt  = pts[nacc];
                bus.in_key = keys[nacc];
                exp_q.push_back(aes_ref(pts[nacc], keys[nacc]));
                acc_cyc.push_back(cyc);
                nacc++;
            end else if (nacc == 4) begin
                bus.in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_outputs", 128'(nout), 128'(4));
        chk("b2b_accepts", 128'(acc_cyc.size()), 128'(4));
        if (acc_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b_period", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop if the run wedges somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
